// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice of the WIDTH-bit operation per clock,
// with a valid/ready handshake on each side and the carry rippling through a register.
module serial_chunk_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   SUM,
   output logic             OVF,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = $clog2(NCHUNK + 1);
   localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(NCHUNK);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic             msb_cin;
   logic [IDX_W-1:0] idx;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_out;
   logic             chunk_msb_cin;

   // Operands shift down one chunk per RUN edge, so the active slice is always the bottom one.
   assign a_chunk = a_reg[CHUNK-1:0];
   assign b_chunk = b_reg[CHUNK-1:0];
   assign {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
   assign chunk_msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         SUM       <= '0;
         OVF       <= 1'b0;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry     <= 1'b0;
         msb_cin   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= A;
                  b_reg    <= SUB ? ~B : B;
                  carry    <= SUB ? 1'b1 : CIN;
                  idx      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (idx != FINAL_IDX) begin
                  SUM[int'(idx)*CHUNK +: CHUNK] <= s_chunk;
                  carry   <= c_out;
                  msb_cin <= chunk_msb_cin;
                  a_reg   <= a_reg >> CHUNK;
                  b_reg   <= b_reg >> CHUNK;
                  idx     <= idx + IDX_W'(1);
               end else begin
                  // Edge after the top chunk: publish carry-out and signed overflow.
                  SUM[WIDTH] <= carry;
                  OVF        <= carry ^ msb_cin;
                  state      <= DONE;
                  out_valid  <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
